// File: rtl/axi_wr_burst_engine.sv
// AXI4 write front end: queues AW requests, expands each burst into per-beat
// {id, addr, data, strb} payloads for the bridge FIFO, and returns one B per burst.
module axi_wr_burst_engine #(
  parameter int ID_W     = 4,
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 32,
  parameter int AW_DEPTH = 4
) (
  input  logic                                     ACLK_i,
  input  logic                                     ARESET_i,
  input  logic [ID_W-1:0]                          AWID_i,
  input  logic [ADDR_W-1:0]                        AWADDR_i,
  input  logic [7:0]                               AWLEN_i,
  input  logic [2:0]                               AWSIZE_i,
  input  logic [1:0]                               AWBURST_i,
  input  logic                                     AWVALID_i,
  output logic                                     AWREADY_o,
  input  logic [DATA_W-1:0]                        WDATA_i,
  input  logic [DATA_W/8-1:0]                      WSTRB_i,
  input  logic                                     WLAST_i,
  input  logic                                     WVALID_i,
  output logic                                     WREADY_o,
  output logic [ID_W-1:0]                          BID_o,
  output logic [1:0]                               BRESP_o,
  output logic                                     BVALID_o,
  input  logic                                     BREADY_i,
  output logic                                     fifo_wvld_o,
  input  logic                                     fifo_wrdy_i,
  output logic [ID_W+ADDR_W+DATA_W+DATA_W/8-1:0]   fifo_wpayload_o
);

  localparam int STRB_W = DATA_W / 8;
  localparam int PTR_W  = $clog2(AW_DEPTH);
  localparam int AWE_W  = ID_W + ADDR_W + 13;
  localparam int XW     = ADDR_W + 16;
  localparam logic [2:0]       MAX_SIZE = 3'($clog2(STRB_W));
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(AW_DEPTH);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DATA = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [AWE_W-1:0]  q_mem [AW_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]    cnt_q, cnt_d;
  logic              awready_q;
  logic              push, pop;

  logic [1:0]        state_q, state_d;
  logic [7:0]        beat_q, beat_d;
  logic              err_q, err_d;
  logic              beat_fire, last_beat;

  logic [ID_W-1:0]   id_q;
  logic [7:0]        len_q;
  logic [2:0]        size_q;
  logic [1:0]        burst_q;
  logic [ADDR_W-1:0] cur_addr_q, wb_q, wend_q, next_addr;

  logic [ID_W-1:0]   h_id;
  logic [ADDR_W-1:0] h_addr, h_wb;
  logic [7:0]        h_len;
  logic [2:0]        h_size;
  logic [1:0]        h_burst;
  logic [XW-1:0]     h_bytes, h_total, bytes_c;
  logic [ADDR_W-1:0] incr_addr, wrap_addr;
  logic              h_len_ok, h_err;

  assign push = AWVALID_i & awready_q;
  assign pop  = (state_q == S_IDLE) & (cnt_q != '0);
  assign {h_id, h_addr, h_len, h_size, h_burst} = q_mem[rd_ptr_q];

  // Burst legality and wrap window are decided once, when the head is popped.
  always_comb begin
    h_bytes  = XW'(1) << h_size;
    h_total  = h_bytes * (XW'(h_len) + XW'(1));
    h_wb     = h_addr & ~ADDR_W'(h_total - XW'(1));
    h_len_ok = (h_len == 8'd1) | (h_len == 8'd3) | (h_len == 8'd7) | (h_len == 8'd15);
    h_err    = (h_size > MAX_SIZE) | (h_burst == 2'b11) |
               ((h_burst == 2'b10) &
                (!h_len_ok | ((h_addr & ADDR_W'(h_bytes - XW'(1))) != '0)));
  end

  always_comb begin
    bytes_c   = XW'(1) << size_q;
    incr_addr = ADDR_W'((XW'(cur_addr_q) & ~(bytes_c - XW'(1))) + bytes_c);
    wrap_addr = cur_addr_q + ADDR_W'(bytes_c);
    if (wrap_addr == wend_q) wrap_addr = wb_q;
    case (burst_q)
      2'b00:   next_addr = cur_addr_q;
      2'b10:   next_addr = wrap_addr;
      default: next_addr = incr_addr;
    endcase
  end

  assign beat_fire = (state_q == S_DATA) & WVALID_i & fifo_wrdy_i;
  assign last_beat = (beat_q == len_q);
  assign cnt_d     = cnt_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          state_d = S_DATA;
          beat_d  = 8'd0;
          err_d   = h_err;
        end
      end
      S_DATA: begin
        if (beat_fire) begin
          beat_d = beat_q + 8'd1;
          if (WLAST_i != last_beat) err_d = 1'b1;
          if (last_beat) state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (BREADY_i) begin
          err_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK_i) begin
    if (ARESET_i) begin
      state_q   <= S_IDLE;
      beat_q    <= 8'd0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      awready_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
      awready_q <= (cnt_d != FULL_CNT);
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

  // Queue storage and burst context carry no reset; control gates their use.
  always_ff @(posedge ACLK_i) begin
    if (push) q_mem[wr_ptr_q] <= {AWID_i, AWADDR_i, AWLEN_i, AWSIZE_i, AWBURST_i};
    if (pop) begin
      id_q       <= h_id;
      len_q      <= h_len;
      size_q     <= h_size;
      burst_q    <= h_burst;
      wb_q       <= h_wb;
      wend_q     <= h_wb + ADDR_W'(h_total);
      cur_addr_q <= h_addr;
    end else if (beat_fire) begin
      cur_addr_q <= next_addr;
    end
  end

  assign AWREADY_o       = awready_q;
  assign WREADY_o        = (state_q == S_DATA) & fifo_wrdy_i;
  assign fifo_wvld_o     = (state_q == S_DATA) & WVALID_i;
  assign fifo_wpayload_o = {id_q, cur_addr_q, WDATA_i, WSTRB_i};
  assign BVALID_o        = (state_q == S_RESP);
  assign BID_o           = BVALID_o ? id_q : '0;
  assign BRESP_o         = (BVALID_o & err_q) ? 2'b10 : 2'b00;

endmodule

// File: tb/tb_axi_wr_burst_engine.sv
// Scoreboard bench for axi_wr_burst_engine: randomized AW/W traffic against a
// closed-form burst address and response model.
module tb_axi_wr_burst_engine;

  localparam int ID_W     = 4;
  localparam int ADDR_W   = 12;
  localparam int DATA_W   = 32;
  localparam int AW_DEPTH = 4;
  localparam int STRB_W   = DATA_W / 8;
  localparam int PAY_W    = ID_W + ADDR_W + DATA_W + STRB_W;

  logic                ACLK_i, ARESET_i;
  logic [ID_W-1:0]     AWID_i;
  logic [ADDR_W-1:0]   AWADDR_i;
  logic [7:0]          AWLEN_i;
  logic [2:0]          AWSIZE_i;
  logic [1:0]          AWBURST_i;
  logic                AWVALID_i, AWREADY_o;
  logic [DATA_W-1:0]   WDATA_i;
  logic [STRB_W-1:0]   WSTRB_i;
  logic                WLAST_i, WVALID_i, WREADY_o;
  logic [ID_W-1:0]     BID_o;
  logic [1:0]          BRESP_o;
  logic                BVALID_o, BREADY_i;
  logic                fifo_wvld_o, fifo_wrdy_i;
  logic [PAY_W-1:0]    fifo_wpayload_o;

  axi_wr_burst_engine #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .AW_DEPTH(AW_DEPTH)) dut (
    .ACLK_i(ACLK_i), .ARESET_i(ARESET_i),
    .AWID_i(AWID_i), .AWADDR_i(AWADDR_i), .AWLEN_i(AWLEN_i), .AWSIZE_i(AWSIZE_i),
    .AWBURST_i(AWBURST_i), .AWVALID_i(AWVALID_i), .AWREADY_o(AWREADY_o),
    .WDATA_i(WDATA_i), .WSTRB_i(WSTRB_i), .WLAST_i(WLAST_i), .WVALID_i(WVALID_i),
    .WREADY_o(WREADY_o), .BID_o(BID_o), .BRESP_o(BRESP_o), .BVALID_o(BVALID_o),
    .BREADY_i(BREADY_i), .fifo_wvld_o(fifo_wvld_o), .fifo_wrdy_i(fifo_wrdy_i),
    .fifo_wpayload_o(fifo_wpayload_o)
  );

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        len;
    logic [2:0]        size;
    logic [1:0]        burst;
  } aw_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [STRB_W-1:0] strb;
    logic              last;
  } w_t;

  aw_t              aw_q[$];
  w_t               w_q[$];
  logic [PAY_W-1:0] exp_pay[$];
  logic [ID_W+1:0]  exp_b[$];

  int n_cmp, n_fail, aw_acc, beats_seen;
  int vld_pct, bready_pct, wrdy_mode;
  bit w_en, mon_en;

  initial begin
    ACLK_i = 1'b0;
    forever #5 ACLK_i = ~ACLK_i;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Beat n address from the burst rules, in closed form.
  function automatic logic [ADDR_W-1:0] beat_addr(input aw_t a, input int n);
    int bytes, total, start, wb, r;
    bytes = 1 << a.size;
    total = bytes * (int'(a.len) + 1);
    start = int'(a.addr);
    case (a.burst)
      2'b00: r = start;
      2'b10: begin
        wb = start - (start % total);
        r  = wb + ((start - wb + n * bytes) % total);
      end
      default: r = (n == 0) ? start : (start - (start % bytes)) + n * bytes;
    endcase
    return ADDR_W'(r);
  endfunction

  function automatic aw_t mk(input int id, input int addr, input int len, input int size, input int burst);
    aw_t a;
    a.id = ID_W'(id); a.addr = ADDR_W'(addr); a.len = 8'(len);
    a.size = 3'(size); a.burst = 2'(burst);
    return a;
  endfunction

  function automatic aw_t rand_aw();
    aw_t a;
    a.id    = ID_W'($urandom);
    a.burst = 2'($urandom_range(3));
    a.size  = 3'($urandom_range(2));
    a.addr  = ADDR_W'($urandom);
    if (a.burst == 2'b10) begin
      case ($urandom_range(3))
        0: a.len = 8'd1;
        1: a.len = 8'd3;
        2: a.len = 8'd7;
        default: a.len = 8'd15;
      endcase
      a.addr = ADDR_W'(int'(a.addr) & ~((1 << a.size) - 1));
    end else begin
      a.len = 8'($urandom_range(15));
      if ($urandom_range(5) == 0) a.size = 3'(3 + $urandom_range(1));
    end
    return a;
  endfunction

  // bad >= 0 flips WLAST on that beat index.
  task automatic add_burst(input aw_t a, input int bad);
    int   bytes;
    logic err;
    w_t   w;
    bytes = 1 << a.size;
    err = (a.size > 3'd2) || (a.burst == 2'b11) ||
          ((a.burst == 2'b10) && (!(a.len inside {8'd1, 8'd3, 8'd7, 8'd15}) ||
                                  ((int'(a.addr) % bytes) != 0)));
    if (bad >= 0) err = 1'b1;
    aw_q.push_back(a);
    for (int n = 0; n <= int'(a.len); n++) begin
      w.data = DATA_W'($urandom);
      w.strb = STRB_W'($urandom);
      w.last = (n == int'(a.len)) ^ (n == bad);
      w_q.push_back(w);
      exp_pay.push_back({a.id, beat_addr(a, n), w.data, w.strb});
    end
    exp_b.push_back({a.id, err ? 2'b10 : 2'b00});
  endtask

  task automatic drive();
    AWVALID_i = (aw_q.size() != 0) && (int'($urandom_range(99)) < vld_pct);
    if (aw_q.size() != 0) begin
      AWID_i = aw_q[0].id; AWADDR_i = aw_q[0].addr; AWLEN_i = aw_q[0].len;
      AWSIZE_i = aw_q[0].size; AWBURST_i = aw_q[0].burst;
    end
    WVALID_i = w_en && (w_q.size() != 0) && (int'($urandom_range(99)) < vld_pct);
    if (w_q.size() != 0) begin
      WDATA_i = w_q[0].data; WSTRB_i = w_q[0].strb; WLAST_i = w_q[0].last;
    end
    case (wrdy_mode)
      0:       fifo_wrdy_i = 1'($urandom_range(1));
      1:       fifo_wrdy_i = 1'b1;
      default: fifo_wrdy_i = ~fifo_wrdy_i;
    endcase
    BREADY_i = int'($urandom_range(99)) < bready_pct;
  endtask

  task automatic cycle();
    bit aw_hs, w_hs;
    w_t dummy_w;
    aw_t dummy_a;
    @(negedge ACLK_i);
    aw_hs = AWVALID_i && AWREADY_o;
    w_hs  = WVALID_i && WREADY_o;
    @(posedge ACLK_i);
    #1;
    if (aw_hs) begin dummy_a = aw_q.pop_front(); aw_acc++; end
    if (w_hs) dummy_w = w_q.pop_front();
    drive();
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    while ((aw_q.size() + w_q.size() + exp_pay.size() + exp_b.size()) != 0 && k < budget) begin
      cycle();
      k++;
    end
    check("drain_complete", 64'((aw_q.size() + w_q.size() + exp_pay.size() + exp_b.size()) == 0), 64'd1);
  endtask

  // Monitor: pops expectations whenever the DUT completes a beat or a response.
  initial begin
    logic [ID_W+1:0]  prev_b;
    logic [PAY_W-1:0] e;
    logic [ID_W+1:0]  eb;
    bit prev_bpend;
    prev_bpend = 1'b0;
    prev_b = '0;
    forever begin
      @(negedge ACLK_i);
      if (ARESET_i || !mon_en) begin
        prev_bpend = 1'b0;
      end else begin
        if (prev_bpend) check("b_hold", 64'({BVALID_o, BID_o, BRESP_o}), 64'({1'b1, prev_b}));
        if (fifo_wvld_o) check("wready_mirror", 64'(WREADY_o), 64'(fifo_wrdy_i));
        if (fifo_wvld_o && fifo_wrdy_i) begin
          beats_seen++;
          if (exp_pay.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL unexpected_beat: got payload %h, none expected", fifo_wpayload_o);
          end else begin
            e = exp_pay.pop_front();
            check("payload", 64'(fifo_wpayload_o), 64'(e));
          end
        end
        if (BVALID_o && BREADY_i) begin
          if (exp_b.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL unexpected_b: got id %h resp %h, none expected", BID_o, BRESP_o);
          end else begin
            eb = exp_b.pop_front();
            check("bresp", 64'({BID_o, BRESP_o}), 64'(eb));
          end
        end
        prev_bpend = BVALID_o && !BREADY_i;
        prev_b     = {BID_o, BRESP_o};
      end
    end
  end

  initial begin
    int base, k;
    aw_t a;
    n_cmp = 0; n_fail = 0; aw_acc = 0; beats_seen = 0;
    vld_pct = 100; bready_pct = 100; wrdy_mode = 1; w_en = 1'b1; mon_en = 1'b0;
    ARESET_i = 1'b1; AWVALID_i = 1'b0; AWID_i = '0; AWADDR_i = '0; AWLEN_i = '0;
    AWSIZE_i = '0; AWBURST_i = '0; WDATA_i = '0; WSTRB_i = '0; WLAST_i = 1'b0;
    WVALID_i = 1'b0; BREADY_i = 1'b0; fifo_wrdy_i = 1'b0;

    repeat (3) @(posedge ACLK_i);
    @(negedge ACLK_i);
    check("rst_awready", 64'(AWREADY_o), 64'd0);
    check("rst_wready", 64'(WREADY_o), 64'd0);
    check("rst_bvalid", 64'(BVALID_o), 64'd0);
    check("rst_fifo_wvld", 64'(fifo_wvld_o), 64'd0);
    check("rst_bid_bresp", 64'({BID_o, BRESP_o}), 64'd0);
    @(posedge ACLK_i); #1;
    ARESET_i = 1'b0;
    @(posedge ACLK_i); #1;
    @(negedge ACLK_i);
    check("awready_after_rst", 64'(AWREADY_o), 64'd1);
    mon_en = 1'b1;

    // Directed INCR and WRAP bursts.
    add_burst(mk(3, 'h104, 3, 2, 1), -1);
    drain(200);
    add_burst(mk(5, 'h038, 3, 2, 2), -1);
    drain(200);

    // Backpressure: toggling downstream ready and gapped WVALID.
    wrdy_mode = 2; vld_pct = 50;
    add_burst(mk(7, 'h200, 7, 2, 1), -1);
    drain(400);

    // Outstanding AWs with W held off: one burst in flight plus a full queue.
    wrdy_mode = 1; vld_pct = 100; w_en = 1'b0; aw_acc = 0;
    for (int i = 0; i < 6; i++) add_burst(mk(8 + i, i * 64, 1, 2, 1), -1);
    repeat (12) cycle();
    check("aw_outstanding", 64'(aw_acc), 64'(AW_DEPTH + 1));
    check("awready_full", 64'(AWREADY_o), 64'd0);
    w_en = 1'b1;
    drain(400);

    // Error cases followed by a clean burst.
    add_burst(mk(1, 'h040, 3, 2, 1), 1);
    add_burst(mk(2, 'h080, 1, 3, 1), -1);
    add_burst(mk(4, 'h010, 2, 2, 3), -1);
    add_burst(mk(6, 'h0C0, 3, 2, 1), -1);
    drain(400);

    // Randomized traffic.
    wrdy_mode = 0; vld_pct = 70; bready_pct = 60;
    for (int i = 0; i < 40; i++) begin
      a = rand_aw();
      add_burst(a, ($urandom_range(7) == 0) ? int'($urandom_range(int'(a.len))) : -1);
    end
    drain(6000);

    // Reset in the middle of a burst.
    wrdy_mode = 1; vld_pct = 100; bready_pct = 100;
    base = beats_seen;
    add_burst(mk(10, 'h300, 5, 2, 1), -1);
    k = 0;
    while (beats_seen < base + 2 && k < 50) begin cycle(); k++; end
    check("reset_setup_beats", 64'(beats_seen - base), 64'd2);
    ARESET_i = 1'b1; AWVALID_i = 1'b0; WVALID_i = 1'b0; fifo_wrdy_i = 1'b0; BREADY_i = 1'b0;
    @(posedge ACLK_i); #1;
    aw_q.delete(); w_q.delete(); exp_pay.delete(); exp_b.delete();
    ARESET_i = 1'b0;
    @(negedge ACLK_i);
    check("midrst_awready", 64'(AWREADY_o), 64'd0);
    check("midrst_wready", 64'(WREADY_o), 64'd0);
    check("midrst_fifo_wvld", 64'(fifo_wvld_o), 64'd0);
    check("midrst_b", 64'({BVALID_o, BID_o, BRESP_o}), 64'd0);
    repeat (10) cycle();
    check("midrst_no_b", 64'(BVALID_o), 64'd0);
    add_burst(mk(12, 'h400, 3, 2, 1), -1);
    drain(200);

    repeat (3) cycle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
